// File: rtl/cpu_bank_reg_pkg.sv
// Shared register-file definitions: architectural sizes, index/data types and
// the index validity rule used by both the storage and the scoreboard.
package cpu_define;

    localparam int NUM_REGS   = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // Write or reservation effect of an index: r0 is hard-wired to zero and
    // indices past the last architectural register do not exist.
    function automatic logic idx_writable(input int unsigned idx,
                                          input int unsigned num_regs);
        return (idx != 0) && (idx < num_regs);
    endfunction

endpackage : cpu_define

// File: rtl/cpu_bank_reg_if.sv
// Decode/writeback side of the register bank: two read ports with busy flags,
// the destination reservation from decode and the writeback strobe.
interface cpu_bank_reg_if
    import cpu_define::*;
#(
    parameter int ADDR_WIDTH = cpu_define::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpu_define::DATA_WIDTH
);

    // Read ports
    logic [ADDR_WIDTH-1:0] read_reg_a;
    logic [ADDR_WIDTH-1:0] read_reg_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic                  busy_a;
    logic                  busy_b;

    // Destination reservation from decode
    logic                  reserve_valid;
    logic [ADDR_WIDTH-1:0] reserve_reg;

    // Writeback
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;

    // Pipeline side: issues indices, reservations and writebacks.
    modport master (
        output read_reg_a, read_reg_b,
        output reserve_valid, reserve_reg,
        output write_enable, write_reg, write_data,
        input  read_data_a, read_data_b, busy_a, busy_b
    );

    // Register bank side.
    modport slave (
        input  read_reg_a, read_reg_b,
        input  reserve_valid, reserve_reg,
        input  write_enable, write_reg, write_data,
        output read_data_a, read_data_b, busy_a, busy_b
    );

endinterface : cpu_bank_reg_if

// File: rtl/cpu_bank_reg_scoreboard.sv
// Register scoreboard: one busy bit per register, set by a decode reservation,
// cleared by writeback, and reported per read port with writeback forwarding.
module cpu_scoreboard
    import cpu_define::idx_writable;
#(
    parameter int NUM_REGS   = cpu_define::NUM_REGS,
    parameter int ADDR_WIDTH = cpu_define::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reserve_valid_i,
    input  logic [ADDR_WIDTH-1:0] reserve_reg_i,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_reg_i,
    input  logic [ADDR_WIDTH-1:0] read_reg_a_i,
    input  logic [ADDR_WIDTH-1:0] read_reg_b_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_ok;
    logic                clr_ok;

    function automatic logic idx_ok(input logic [ADDR_WIDTH-1:0] idx);
        return idx_writable(32'(idx), NUM_REGS);
    endfunction

    assign set_ok = reserve_valid_i && idx_ok(reserve_reg_i);
    assign clr_ok = write_enable_i  && idx_ok(write_reg_i);

    // Next busy vector: clear on writeback, then set on reservation so a
    // same-cycle reserve of the written register stays busy (newer writer).
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        busy_d = busy_q;
        if (clr_ok) begin
            busy_d[write_reg_i] = 1'b0;
        end
        if (set_ok) begin
            busy_d[reserve_reg_i] = 1'b1;
        end
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of block ordering.
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Port A busy: pending unless this cycle's writeback resolves it.
    always_comb begin
        busy_a_o = 1'b0;
        if (idx_ok(read_reg_a_i)) begin
            busy_a_o = busy_q[read_reg_a_i] &&
                       !(write_enable_i && (write_reg_i == read_reg_a_i));
        end
    end

    // Port B busy: same rule as port A.
    always_comb begin
        busy_b_o = 1'b0;
        if (idx_ok(read_reg_b_i)) begin
            busy_b_o = busy_q[read_reg_b_i] &&
                       !(write_enable_i && (write_reg_i == read_reg_b_i));
        end
    end

endmodule : cpu_scoreboard

// File: rtl/cpu_bank_reg.sv
// Architectural register bank: two combinational read ports with writeback
// bypass, one write port, r0 hard-wired to zero, and a scoreboard tracking
// registers with an outstanding writer.
module cpu_bank_reg
    import cpu_define::idx_writable;
#(
    parameter int NUM_REGS   = cpu_define::NUM_REGS,
    parameter int DATA_WIDTH = cpu_define::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_define::ADDR_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    cpu_bank_reg_if.slave  bus
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  write_ok;

    function automatic logic idx_ok(input logic [ADDR_WIDTH-1:0] idx);
        return idx_writable(32'(idx), NUM_REGS);
    endfunction

    assign write_ok = bus.write_enable && idx_ok(bus.write_reg);

    // Register storage: cleared by reset, updated by writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the storage array is reset on purpose: the architecture
            // requires every register to read zero after reset, which rules
            // out a non-resettable RAM macro for this bank.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_ok) begin
            regs_q[bus.write_reg] <= bus.write_data;
        end
    end

    // Port A read: zero for r0/out-of-range, writeback data when bypassing.
    always_comb begin
        bus.read_data_a = '0;
        if (idx_ok(bus.read_reg_a)) begin
            if (write_ok && (bus.write_reg == bus.read_reg_a)) begin
                bus.read_data_a = bus.write_data;
            end else begin
                bus.read_data_a = regs_q[bus.read_reg_a];
            end
        end
    end

    // Port B read: same rule as port A.
    always_comb begin
        bus.read_data_b = '0;
        if (idx_ok(bus.read_reg_b)) begin
            if (write_ok && (bus.write_reg == bus.read_reg_b)) begin
                bus.read_data_b = bus.write_data;
            end else begin
                bus.read_data_b = regs_q[bus.read_reg_b];
            end
        end
    end

    cpu_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clock           (clock),
        .reset           (reset),
        .reserve_valid_i (bus.reserve_valid),
        .reserve_reg_i   (bus.reserve_reg),
        .write_enable_i  (bus.write_enable),
        .write_reg_i     (bus.write_reg),
        .read_reg_a_i    (bus.read_reg_a),
        .read_reg_b_i    (bus.read_reg_b),
        .busy_a_o        (bus.busy_a),
        .busy_b_o        (bus.busy_b)
    );

endmodule : cpu_bank_reg

// File: tb/tb_cpu_bank_reg.sv
// Directed bench for cpu_bank_reg: reset state, write/read, bypass, r0,
// scoreboard set/clear ordering and reset with operations in flight.
module tb_cpu_bank_reg;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clock;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    cpu_bank_reg_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cpu_bank_reg #(.NUM_REGS(32), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Commit at the next rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.reserve_valid = 1'b0;
        bus.reserve_reg   = '0;
        bus.write_enable  = 1'b0;
        bus.write_reg     = '0;
        bus.write_data    = '0;
    endtask

    task automatic test_reset();
        // Writes and reservations during reset must be ignored.
        reset = 1'b1;
        bus.write_enable  = 1'b1;
        bus.write_reg     = 5'd4;
        bus.write_data    = 32'hCAFE_F00D;
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd4;
        tick();
        tick();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin
            bus.read_reg_a = AW'(i);
            bus.read_reg_b = AW'(31 - i);
            #1;
            vectors++;
            if (bus.read_data_a !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_data_a idx=%0d got=%h exp=0", i, bus.read_data_a);
            end
            vectors++;
            if (bus.read_data_b !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_data_b idx=%0d got=%h exp=0", 31 - i, bus.read_data_b);
            end
            vectors++;
            if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_busy idx=%0d got=%b%b exp=00", i, bus.busy_a, bus.busy_b);
            end
        end
    endtask

    task automatic test_write_read();
        bus.write_enable = 1'b1;
        bus.write_reg    = 5'd5;
        bus.write_data   = 32'hDEAD_BEEF;
        bus.read_reg_a   = 5'd1;
        tick();
        bus.write_reg    = 5'd31;
        bus.write_data   = 32'hA5A5_A5A5;
        tick();
        idle();
        bus.read_reg_a = 5'd5;
        bus.read_reg_b = 5'd31;
        #1;
        vectors++;
        if (bus.read_data_a !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_read_r5 got=%h exp=deadbeef", bus.read_data_a);
        end
        vectors++;
        if (bus.read_data_b !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL write_read_r31 got=%h exp=a5a5a5a5", bus.read_data_b);
        end
        // Neighbour registers untouched.
        bus.read_reg_a = 5'd4;
        bus.read_reg_b = 5'd6;
        #1;
        vectors++;
        if (bus.read_data_a !== 32'h0 || bus.read_data_b !== 32'h0) begin
            miscompares++;
            $display("FAIL write_read_neighbours got=%h/%h exp=0/0", bus.read_data_a, bus.read_data_b);
        end
    endtask

    task automatic test_bypass();
        bus.write_enable = 1'b1;
        bus.write_reg    = 5'd7;
        bus.write_data   = 32'h1234_5678;
        bus.read_reg_a   = 5'd7;
        bus.read_reg_b   = 5'd7;
        #1;
        vectors++;
        if (bus.read_data_b !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL bypass_b got=%h exp=12345678", bus.read_data_b);
        end
        vectors++;
        if (bus.read_data_a !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL bypass_a got=%h exp=12345678", bus.read_data_a);
        end
        // Bypass overrides stale stored data of r5.
        bus.write_reg  = 5'd5;
        bus.write_data = 32'h0BAD_CAFE;
        bus.read_reg_a = 5'd5;
        #1;
        vectors++;
        if (bus.read_data_a !== 32'h0BAD_CAFE) begin
            miscompares++;
            $display("FAIL bypass_over_stored got=%h exp=0badcafe", bus.read_data_a);
        end
        bus.write_enable = 1'b0;
        #1;
        vectors++;
        if (bus.read_data_a !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL bypass_off got=%h exp=deadbeef", bus.read_data_a);
        end
        bus.write_reg    = 5'd7;
        bus.write_data   = 32'h1234_5678;
        bus.write_enable = 1'b1;
        tick();
        idle();
        #1;
        vectors++;
        if (bus.read_data_b !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL bypass_stored got=%h exp=12345678", bus.read_data_b);
        end
    endtask

    task automatic test_reg0();
        bus.write_enable  = 1'b1;
        bus.write_reg     = 5'd0;
        bus.write_data    = 32'hFFFF_FFFF;
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd0;
        bus.read_reg_a    = 5'd0;
        #1;
        vectors++;
        if (bus.read_data_a !== 32'h0 || bus.busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_same_cycle got=%h busy=%b exp=0 busy=0", bus.read_data_a, bus.busy_a);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus.read_data_a !== 32'h0 || bus.busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_after got=%h busy=%b exp=0 busy=0", bus.read_data_a, bus.busy_a);
        end
    endtask

    task automatic test_scoreboard();
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd3;
        bus.read_reg_a    = 5'd3;
        bus.read_reg_b    = 5'd3;
        #1;
        vectors++;
        if (bus.busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_reserve_same_cycle got=%b exp=0", bus.busy_a);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b1 || bus.busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_reserved got=%b%b exp=11", bus.busy_a, bus.busy_b);
        end
        // Other registers stay free.
        bus.read_reg_b = 5'd2;
        #1;
        vectors++;
        if (bus.busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_other_free got=%b exp=0", bus.busy_b);
        end
        // Writeback hides busy in the write cycle.
        bus.write_enable = 1'b1;
        bus.write_reg    = 5'd3;
        bus.write_data   = 32'h0000_0033;
        #1;
        vectors++;
        if (bus.busy_a !== 1'b0 || bus.read_data_a !== 32'h33) begin
            miscompares++;
            $display("FAIL sb_write_cycle got=%b/%h exp=0/00000033", bus.busy_a, bus.read_data_a);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b0 || bus.read_data_a !== 32'h33) begin
            miscompares++;
            $display("FAIL sb_after_write got=%b/%h exp=0/00000033", bus.busy_a, bus.read_data_a);
        end
        // Reserve and write together: reservation wins.
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd3;
        bus.write_enable  = 1'b1;
        bus.write_reg     = 5'd3;
        bus.write_data    = 32'h0000_0044;
        tick();
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b1 || bus.read_data_a !== 32'h44) begin
            miscompares++;
            $display("FAIL sb_reserve_and_write got=%b/%h exp=1/00000044", bus.busy_a, bus.read_data_a);
        end
        // Re-reserving a busy register keeps it busy; one write clears it.
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd3;
        tick();
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_double_reserve got=%b exp=1", bus.busy_a);
        end
        bus.write_enable = 1'b1;
        bus.write_reg    = 5'd3;
        bus.write_data   = 32'h0000_0055;
        tick();
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_single_clear got=%b exp=0", bus.busy_a);
        end
    endtask

    task automatic test_reset_in_flight();
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd9;
        bus.write_enable  = 1'b1;
        bus.write_reg     = 5'd9;
        bus.write_data    = 32'h0000_0055;
        bus.read_reg_a    = 5'd9;
        tick();
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b1 || bus.read_data_a !== 32'h55) begin
            miscompares++;
            $display("FAIL rif_before got=%b/%h exp=1/00000055", bus.busy_a, bus.read_data_a);
        end
        // Reset with another reserve+write to r9 in flight.
        reset             = 1'b1;
        bus.reserve_valid = 1'b1;
        bus.reserve_reg   = 5'd9;
        bus.write_enable  = 1'b1;
        bus.write_reg     = 5'd9;
        bus.write_data    = 32'h0000_0066;
        tick();
        reset = 1'b0;
        idle();
        #1;
        vectors++;
        if (bus.busy_a !== 1'b0 || bus.read_data_a !== 32'h0) begin
            miscompares++;
            $display("FAIL rif_after got=%b/%h exp=0/00000000", bus.busy_a, bus.read_data_a);
        end
        bus.read_reg_b = 5'd5;
        #1;
        vectors++;
        if (bus.read_data_b !== 32'h0) begin
            miscompares++;
            $display("FAIL rif_r5_cleared got=%h exp=0", bus.read_data_b);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.read_reg_a = '0;
        bus.read_reg_b = '0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_reg0();
        test_scoreboard();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cpu_bank_reg
